book_msg_arb: RTL and testbench
===============================

Name: book_msg_arb

Overview:
- Round-robin arbiter that merges N_REQ book_msg_t streams into the single orderbook input channel. Sources include multiple itch_parser instances and an HPS-injected command stream.
- Sits between the parsers and orderbook inside hft_top.
- Provides a registered output stage, per-source message counters, and a pause/drain handshake so HPS can quiesce the book safely.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 32, width of per-requester accepted-message counters.

Ports:
- clk_100  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester message valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_msg  in  N_REQ x book_msg_t  per-requester message.
- out_valid  out  1  message valid to orderbook.
- out_ready  in  1  orderbook accept.
- out_msg  out  book_msg_t  registered message.
- out_src  out  $clog2(N_REQ)  index of the requester that supplied out_msg.
- pause_req  in  1  HPS level request to stop granting and drain.
- paused  out  1  high when drained and no grants are in progress.
- cnt_sel  in  $clog2(N_REQ)  counter read select.
- cnt_value  out  CNT_W  accepted-message count of requester cnt_sel (combinational read).

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_msg='0, out_src=0, paused=0, state=RUN, rr_ptr=0, all counters=0.
  - req_ready is 0 during reset.
- Reset mid-operation discards any message held in the output register.
- Output register:
  - load_en = !out_valid || out_ready.
  - Full throughput is one message per cycle; latency from req accept to out_valid is exactly 1 cycle.
  - out_valid holds, with out_msg and out_src stable, until out_ready is high.
- Grant:
  - grant_ok = (state==RUN) && !pause_req && load_en.
  - When grant_ok is high, the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, … mod N_REQ, gets req_ready[i]=1.
  - On that accept: out_msg<=req_msg[i], out_src<=i, out_valid<=1, rr_ptr<=(i+1) mod N_REQ, cnt[i]<=cnt[i]+1 (wraps at 2^CNT_W).
- No accept: rr_ptr is unchanged.
- If load_en is high and no accept occurs, out_valid<=0.
- req_ready never depends on req_valid of other requesters beyond the priority selection. There is no combinational path from out_ready to out_valid.
- State machine (state register, 2 bits):
  - RUN → DRAIN when pause_req=1.
  - DRAIN → PAUSED when out_valid=0, or when out_valid=1 && out_ready=1 in that cycle.
  - PAUSED → RUN when pause_req=0.
  - DRAIN → RUN when pause_req drops before drain completes.
  - paused=1 only in PAUSED, registered.
- Simultaneous events:
  - pause_req rising in the same cycle as a pending request: no grant that cycle.
  - A requester whose req_valid drops without being granted is simply skipped; no error.

Optional Feature:
- Macro: BOOK_ARB_STRICT_PRIO_EN.
- Defined: requester 0, the HPS command path, has strict priority. If req_valid[0] and grant_ok, it is granted regardless of rr_ptr, and rr_ptr is unchanged. Requesters 1..N_REQ-1 round-robin among themselves.
- Undefined: all requesters are in one plain round-robin ring as above.

Decomposition:
- hft_pkg holds:
  - book_msg_t (shared with itch_parser/orderbook).
  - arb_state_t enum {ARB_RUN, ARB_DRAIN, ARB_PAUSED}.
  - Constant ARB_MAX_REQ=8.
- One sub-module: rr_pick, combinational. Inputs: req vector, ptr. Outputs: one-hot grant and encoded index.
- book_msg_arb owns the pointer, output register, counters and FSM.

Test Plan:
- Reset then all 4 req_valid=1, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3; one message per cycle; each cnt_value=2.
- Only req 2 valid, out_ready low for 3 cycles → req_ready[2] high once; out_msg/out_src=2 stable 3 cycles; no second accept until out_ready=1.
- out_valid=1, out_ready=0, pause_req=1 → no grants, state DRAIN. Release out_ready → out_valid falls; paused=1 next cycle. Drop pause_req → grants resume from rr_ptr.
- rst_n asserted low mid-stream while out_valid=1 → out_valid=0 immediately; counters=0; after release, first grant goes to req 0.
- With BOOK_ARB_STRICT_PRIO_EN and reqs 0,1,3 continuously valid → req 0 granted every cycle; reqs 1,3 starve. Drop req 0 → 1,3 alternate.
- Counter wrap with CNT_W=4 → 16 accepts from req 1 return cnt_value to 0.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared types for the HFT datapath: the book message carried between the
// ITCH parsers, the message arbiter and the orderbook, plus arbiter state.
package hft_pkg;

  localparam int ARB_MAX_REQ = 8;

  typedef struct packed {
    logic [1:0]  op;        // add / cancel / execute / delete
    logic        side;      // 0 = bid, 1 = ask
    logic [31:0] order_id;
    logic [31:0] price;
    logic [31:0] qty;
  } book_msg_t;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_PAUSED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first set bit of req, searching from
// ptr upward and wrapping modulo N.
// Ports:
//   req   - request vector
//   ptr   - search start index (0..N-1)
//   grant - one-hot grant (all zero when req is zero)
//   idx   - encoded grant index (0 when req is zero)
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [N-1:0]   rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] sum;
  logic [IDX_W:0] sel;
  logic           hit;

  // Rotate so that bit 0 of rot corresponds to requester ptr.
  assign rot = N'({req, req} >> ptr);

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    off = '0;
    hit = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = (IDX_W + 1)'(j);
        hit = 1'b1;
      end
    end
  end

  // ptr + off is at most 2N-2, so one conditional subtract restores mod N.
  assign sum   = {1'b0, ptr} + off;
  assign sel   = (sum >= N_W) ? (sum - N_W) : sum;
  assign idx   = IDX_W'(sel);
  assign grant = hit ? (N'(1) << sel) : '0;

endmodule

// File: rtl/book_msg_arb.sv
// Round-robin merge of N_REQ book_msg_t streams into the orderbook input,
// with a registered output stage, per-source accept counters and a
// pause/drain handshake for quiescing the book from the HPS.
//
// Optional build macro BOOK_ARB_STRICT_PRIO_EN: requester 0 (HPS command
// path) wins whenever valid, without moving the pointer; requesters
// 1..N_REQ-1 round-robin among themselves. Undefined: one plain ring.
//
// Ports:
//   clk_100, rst_n         - clock, async active-low reset
//   req_valid/ready/msg    - per-requester handshake (N_REQ = 2..8)
//   out_valid/ready/msg    - registered output to the orderbook
//   out_src                - requester index that supplied out_msg
//   pause_req, paused      - HPS quiesce request / drained indication
//   cnt_sel, cnt_value     - combinational read of accept counters
//
// state      | meaning
// ARB_RUN    | granting normally
// ARB_DRAIN  | no grants, waiting for the output register to empty
// ARB_PAUSED | drained and idle until pause_req drops
module book_msg_arb
  import hft_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int CNT_W = 32,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk_100,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  book_msg_t          req_msg [N_REQ],
  output logic               out_valid,
  input  logic               out_ready,
  output book_msg_t          out_msg,
  output logic [IDX_W-1:0]   out_src,
  input  logic               pause_req,
  output logic               paused,
  input  logic [IDX_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]   cnt_value
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt [N_REQ];

  logic             load_en;
  logic             grant_ok;
  logic             accept;
  logic [N_REQ-1:0] pick_req;
  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] acc_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             keep_ptr;

  assign load_en  = !out_valid || out_ready;
  // rst_n gating keeps req_ready low while reset is held, since the reset
  // state (RUN, output empty) would otherwise allow grants.
  assign grant_ok = rst_n && (state_q == ARB_RUN) && !pause_req && load_en;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

`ifdef BOOK_ARB_STRICT_PRIO_EN
  assign pick_req = {req_valid[N_REQ-1:1], 1'b0};

  always_comb begin
    grant    = pick_grant;
    acc_idx  = pick_idx;
    keep_ptr = 1'b0;
    if (req_valid[0]) begin
      grant    = N_REQ'(1);
      acc_idx  = '0;
      keep_ptr = 1'b1;
    end
  end
`else
  assign pick_req = req_valid;
  assign grant    = pick_grant;
  assign acc_idx  = pick_idx;
  assign keep_ptr = 1'b0;
`endif

  assign req_ready = grant_ok ? grant : '0;
  assign accept    = |req_ready;
  assign next_ptr  = (acc_idx == IDX_W'(N_REQ - 1)) ? '0 : acc_idx + IDX_W'(1);

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_msg   <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load_en) begin
        out_valid <= accept;
        if (accept) begin
          out_msg <= req_msg[acc_idx];
          out_src <= acc_idx;
        end
      end
      if (accept && !keep_ptr) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else if (accept) begin
      cnt[acc_idx] <= cnt[acc_idx] + CNT_W'(1);
    end
  end

  assign cnt_value = (int'(cnt_sel) < N_REQ) ? cnt[cnt_sel] : '0;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN: begin
        if (pause_req) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!pause_req)                    state_d = ARB_RUN;
        else if (!out_valid || out_ready)  state_d = ARB_PAUSED;
      end
      ARB_PAUSED: begin
        if (!pause_req) state_d = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  assign paused = (state_q == ARB_PAUSED);

endmodule

// File: tb/tb_book_msg_arb.sv
module tb_book_msg_arb;
  import hft_pkg::*;

  logic       clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic       rst_n;
  logic [3:0] req_valid, req_valid_w;
  logic [3:0] req_ready, req_ready_w;
  book_msg_t  req_msg [4];
  logic       out_valid, out_valid_w;
  logic       out_ready;
  book_msg_t  out_msg, out_msg_w;
  logic [1:0] out_src, out_src_w;
  logic       pause_req;
  logic       paused, paused_w;
  logic [1:0] cnt_sel;
  logic [31:0] cnt_value;
  logic [3:0]  cnt_value_w;

  int n_vec = 0;
  int n_err = 0;

  book_msg_arb #(.N_REQ(4), .CNT_W(32)) u_dut (
    .clk_100(clk_100), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_msg(req_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg), .out_src(out_src),
    .pause_req(pause_req), .paused(paused),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value)
  );

  // Narrow-counter instance for the wrap check; only requester 1 is driven.
  book_msg_arb #(.N_REQ(4), .CNT_W(4)) u_dut_w (
    .clk_100(clk_100), .rst_n(rst_n),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_msg(req_msg),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_msg(out_msg_w), .out_src(out_src_w),
    .pause_req(pause_req), .paused(paused_w),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value_w)
  );

  function automatic book_msg_t mk(int src, int seq);
    book_msg_t m;
    m          = '0;
    m.op       = 2'(src);
    m.side     = src[0];
    m.order_id = 32'(src * 1000 + seq);
    m.price    = 32'(100 + src);
    m.qty      = 32'(seq + 1);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 4'hF; req_valid_w = 4'h0;
    out_ready = 1'b1; pause_req = 1'b0; cnt_sel = 2'd0;
    for (int i = 0; i < 4; i++) req_msg[i] = mk(i, 0);
    #2 rst_n = 1'b0;
    tick(); tick();
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_vec++; if (out_src !== 2'd0) begin n_err++; $display("FAIL rst_out_src got %0d exp 0", out_src); end
    n_vec++; if (out_msg !== book_msg_t'('0)) begin n_err++; $display("FAIL rst_out_msg got %h exp 0", out_msg); end
    n_vec++; if (paused !== 1'b0) begin n_err++; $display("FAIL rst_paused got %b exp 0", paused); end
    n_vec++; if (cnt_value !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", cnt_value); end
    req_valid = 4'h0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    req_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'(1 << (k % 4));
      #1;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4)) begin
        n_err++; $display("FAIL rr_out[%0d] got v=%b src=%0d exp v=1 src=%0d", k, out_valid, out_src, k % 4);
      end
      n_vec++; if (out_msg !== mk(k % 4, 0)) begin n_err++; $display("FAIL rr_msg[%0d] got %h exp %h", k, out_msg, mk(k % 4, 0)); end
    end
    req_valid = 4'h0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle_valid got %b exp 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      n_vec++; if (cnt_value !== 32'd2) begin n_err++; $display("FAIL rr_cnt[%0d] got %0d exp 2", i, cnt_value); end
    end
  endtask

  task automatic test_backpressure();
    // pointer is 0 here; only requester 2 is asking
    req_valid = 4'b0100; out_ready = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_first_ready got %b exp 0100", req_ready); end
    tick();
    for (int h = 0; h < 3; h++) begin
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_hold_ready[%0d] got %b exp 0000", h, req_ready); end
      n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_msg !== mk(2, 0)) begin
        n_err++; $display("FAIL bp_hold_out[%0d] got v=%b src=%0d msg=%h exp v=1 src=2 msg=%h", h, out_valid, out_src, out_msg, mk(2, 0));
      end
      tick();
    end
    req_msg[2] = mk(2, 1); out_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready got %b exp 0100", req_ready); end
    tick();
    n_vec++; if (out_msg !== mk(2, 1) || out_src !== 2'd2) begin n_err++; $display("FAIL bp_second_msg got %h src=%0d exp %h src=2", out_msg, out_src, mk(2, 1)); end
    req_valid = 4'h0;
    tick();
    cnt_sel = 2'd2;
    #1;
    n_vec++; if (cnt_value !== 32'd4) begin n_err++; $display("FAIL bp_cnt2 got %0d exp 4", cnt_value); end
  endtask

  task automatic test_pause_drain();
    // pointer is 3; requester 0 found after wrapping
    req_valid = 4'b0001; out_ready = 1'b0; req_msg[0] = mk(0, 5);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL pd_first_ready got %b exp 0001", req_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin n_err++; $display("FAIL pd_loaded got v=%b src=%0d exp v=1 src=0", out_valid, out_src); end
    pause_req = 1'b1; req_valid = 4'hF;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL pd_pause_ready got %b exp 0000", req_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || paused !== 1'b0) begin n_err++; $display("FAIL pd_drain got v=%b paused=%b exp v=1 paused=0", out_valid, paused); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL pd_drain_ready got %b exp 0000", req_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || paused !== 1'b1) begin n_err++; $display("FAIL pd_paused got v=%b paused=%b exp v=0 paused=1", out_valid, paused); end
    tick();
    n_vec++; if (req_ready !== 4'b0000 || paused !== 1'b1) begin n_err++; $display("FAIL pd_hold got rdy=%b paused=%b exp rdy=0000 paused=1", req_ready, paused); end
    pause_req = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL pd_unpause_ready got %b exp 0000", req_ready); end
    tick();
    n_vec++; if (paused !== 1'b0 || req_ready !== 4'b0010) begin n_err++; $display("FAIL pd_resume got paused=%b rdy=%b exp paused=0 rdy=0010", paused, req_ready); end
    tick();
    n_vec++; if (out_src !== 2'd1 || out_msg !== mk(1, 0)) begin n_err++; $display("FAIL pd_resume_out got src=%0d msg=%h exp src=1 msg=%h", out_src, out_msg, mk(1, 0)); end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_reset_midstream();
    // pointer is 2
    req_valid = 4'hF; out_ready = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin n_err++; $display("FAIL mr_loaded got v=%b src=%0d exp v=1 src=2", out_valid, out_src); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || req_ready !== 4'b0000 || out_src !== 2'd0) begin
      n_err++; $display("FAIL mr_async got v=%b rdy=%b src=%0d exp v=0 rdy=0000 src=0", out_valid, req_ready, out_src);
    end
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      n_vec++; if (cnt_value !== 32'd0) begin n_err++; $display("FAIL mr_cnt[%0d] got %0d exp 0", i, cnt_value); end
    end
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mr_first_ready got %b exp 0001", req_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin n_err++; $display("FAIL mr_first_out got v=%b src=%0d exp v=1 src=0", out_valid, out_src); end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_prio_pattern();
    int exp_src [10];
`ifdef BOOK_ARB_STRICT_PRIO_EN
    exp_src = '{0, 0, 0, 0, 0, 0, 1, 3, 1, 3};
`else
    exp_src = '{0, 1, 3, 0, 1, 3, 1, 3, 1, 3};
`endif
    rst_n = 1'b0; #2 rst_n = 1'b1;
    req_valid = 4'b1011; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) req_valid = 4'b1010;
      #1;
      n_vec++; if (req_ready !== 4'(1 << exp_src[k])) begin n_err++; $display("FAIL pr_ready[%0d] got %b exp src %0d", k, req_ready, exp_src[k]); end
      tick();
      n_vec++; if (out_src !== 2'(exp_src[k])) begin n_err++; $display("FAIL pr_src[%0d] got %0d exp %0d", k, out_src, exp_src[k]); end
    end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_counter_wrap();
    rst_n = 1'b0; #2 rst_n = 1'b1;
    req_valid_w = 4'b0010; out_ready = 1'b1; cnt_sel = 2'd1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_vec++; if (cnt_value_w !== 4'(k % 16)) begin n_err++; $display("FAIL wrap_cnt[%0d] got %0d exp %0d", k, cnt_value_w, k % 16); end
    end
    req_valid_w = 4'h0;
    n_vec++; if (out_src_w !== 2'd1 || out_valid_w !== 1'b1) begin n_err++; $display("FAIL wrap_out got src=%0d v=%b exp src=1 v=1", out_src_w, out_valid_w); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_pause_drain();
    test_reset_midstream();
    test_prio_pattern();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
